// File: rtl/bram_stream_pkg.sv
// Shared types and elaboration helpers for the BRAM-to-AXI4-Stream reader.
//   state_e        : controller state encoding (IDLE, RUN, DRAIN)
//   fifo_ptr_w()   : pointer width for a power-of-2 FIFO, one wrap bit included
//   rd_latency_ok(): legal BRAM read latencies
package bram_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit rd_latency_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : synchronous empty, discards contents (wins over write)
//   wr_en/wr_data : push side
//   rd_en         : pop request; ignored when empty
//   rd_data       : head word, valid while rd_valid is high
//   count         : current occupancy, 0..DEPTH
module stream_fifo
    import bram_stream_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int PTR_W = fifo_ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [PTR_W-1:0] count
);

    localparam int IDX_W = PTR_W - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             empty;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                   (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);
    assign do_rd = rd_en && !empty;
    // When full, a write is only accepted alongside a pop: the head slot is
    // read combinationally this cycle and overwritten at the edge.
    assign do_wr = wr_en && (!full || do_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_wr);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_rd);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !flush) begin
            mem[wr_ptr_q[IDX_W-1:0]] <= wr_data;
        end
    end

    assign rd_data  = mem[rd_ptr_q[IDX_W-1:0]];
    assign rd_valid = !empty;
    assign count    = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/bram_pixel_streamer.sv
// Reads a contiguous run of BRAM words and emits them as an AXI4-Stream master.
//
// state | meaning
// IDLE  | waiting for cfg_start
// RUN   | issuing BRAM reads while credits are available
// DRAIN | all reads issued, waiting for returns and FIFO to empty
//
//   ACLK, ARESET            : clock, synchronous active-high reset
//   cfg_start/cfg_abort     : one-cycle control pulses
//   cfg_base_addr/cfg_length: transfer window, sampled when start is accepted
//   stat_busy/done/count    : status back to the register block
//   bram_en/addr/dout       : BRAM read port, data RD_LATENCY cycles after en
//   m_axis_*                : stream master
module bram_pixel_streamer
    import bram_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cfg_start,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [ADDR_WIDTH:0]   cfg_length,
    input  logic                  cfg_abort,
    output logic                  stat_busy,
    output logic                  stat_done,
    output logic [ADDR_WIDTH:0]   stat_count,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam int PTR_W = fifo_ptr_w(FIFO_DEPTH);
    localparam int CRD_W = PTR_W + 1;

    if (!rd_latency_ok(RD_LATENCY) || (FIFO_DEPTH < RD_LATENCY + 2) ||
        ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_param_check
        $error("bram_pixel_streamer: illegal RD_LATENCY or FIFO_DEPTH");
    end

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        left_q, left_d;
    logic [LEN_W-1:0]        count_q, count_d;
    logic [RD_LATENCY-1:0]   vld_q, vld_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [PTR_W-1:0]        fifo_cnt;
    logic                    fifo_valid;
    logic [DATA_WIDTH-1:0]   fifo_head;
    logic [CRD_W-1:0]        inflight;
    logic [CRD_W-1:0]        credit_used;
    logic                    issue;
    logic                    pop;
    logic                    abort_now;
    logic                    drained;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CRD_W'(vld_q[i]);
        end
    end

    // Every issued read owns a FIFO slot until it is popped, so a returning
    // word always has room even if the sink stalls indefinitely.
    assign credit_used = inflight + CRD_W'(fifo_cnt);
    assign issue       = (state_q == ST_RUN) && (credit_used < CRD_W'(FIFO_DEPTH));
    assign pop         = fifo_valid && m_axis_tready;
    assign abort_now   = cfg_abort && (state_q != ST_IDLE);
    // Leave DRAIN on the edge that pops the final word, not a cycle later.
    assign drained     = (inflight == '0) &&
                         ((fifo_cnt == '0) || ((fifo_cnt == PTR_W'(1)) && pop));

    always_comb begin
        vld_d = '0;
        if (!abort_now) begin
            vld_d[0] = issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        left_d  = left_q;
        count_d = count_q + LEN_W'(pop);
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    addr_d  = cfg_base_addr;
                    len_d   = cfg_length;
                    left_d  = cfg_length;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = (cfg_length == '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    left_d = left_q - LEN_W'(1);
                    if (left_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drained) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (abort_now) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            left_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            left_q  <= left_d;
            count_q <= count_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk      (ACLK),
        .rst      (ARESET),
        .flush    (abort_now),
        .wr_en    (vld_q[RD_LATENCY-1]),
        .wr_data  (bram_dout),
        .rd_en    (pop),
        .rd_data  (fifo_head),
        .rd_valid (fifo_valid),
        .count    (fifo_cnt)
    );

    assign stat_busy     = busy_q;
    assign stat_done     = done_q;
    assign stat_count    = count_q;
    assign bram_en       = issue;
    assign bram_addr     = addr_q;
    assign m_axis_tvalid = fifo_valid;
    assign m_axis_tdata  = fifo_valid ? fifo_head : '0;
    assign m_axis_tlast  = fifo_valid && (count_q == len_q - LEN_W'(1));

endmodule

// File: tb/tb_bram_pixel_streamer.sv
// Directed bench: two streamers (read latency 1 and 2) share the config bus;
// sel routes start/abort/tready to one of them and picks whose outputs are
// observed.
module tb_bram_pixel_streamer;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LW = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sel = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_abort = 1'b0;
    logic          tready = 1'b0;
    logic [AW-1:0] cfg_base = '0;
    logic [LW-1:0] cfg_len = '0;

    always #5 clk = ~clk;

    logic          busy1, done1, en1, tvalid1, tlast1;
    logic          busy2, done2, en2, tvalid2, tlast2;
    logic [LW-1:0] count1, count2;
    logic [AW-1:0] addr1, addr2;
    logic [DW-1:0] dout1, dout2, tdata1, tdata2, pipe2;
    logic [DW-1:0] mem [1024];

    bram_pixel_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .FIFO_DEPTH(4)) u_dut1 (
        .ACLK(clk), .ARESET(rst),
        .cfg_start(cfg_start && !sel), .cfg_base_addr(cfg_base), .cfg_length(cfg_len),
        .cfg_abort(cfg_abort && !sel),
        .stat_busy(busy1), .stat_done(done1), .stat_count(count1),
        .bram_en(en1), .bram_addr(addr1), .bram_dout(dout1),
        .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(tready && !sel),
        .m_axis_tlast(tlast1)
    );

    bram_pixel_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .FIFO_DEPTH(4)) u_dut2 (
        .ACLK(clk), .ARESET(rst),
        .cfg_start(cfg_start && sel), .cfg_base_addr(cfg_base), .cfg_length(cfg_len),
        .cfg_abort(cfg_abort && sel),
        .stat_busy(busy2), .stat_done(done2), .stat_count(count2),
        .bram_en(en2), .bram_addr(addr2), .bram_dout(dout2),
        .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2), .m_axis_tready(tready && sel),
        .m_axis_tlast(tlast2)
    );

    always @(posedge clk) begin
        dout1 <= mem[addr1];
        pipe2 <= mem[addr2];
        dout2 <= pipe2;
    end

    logic          obs_busy, obs_done, obs_en, obs_tvalid, obs_tlast;
    logic [LW-1:0] obs_count;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_tdata;
    assign obs_busy   = sel ? busy2   : busy1;
    assign obs_done   = sel ? done2   : done1;
    assign obs_en     = sel ? en2     : en1;
    assign obs_tvalid = sel ? tvalid2 : tvalid1;
    assign obs_tlast  = sel ? tlast2  : tlast1;
    assign obs_count  = sel ? count2  : count1;
    assign obs_addr   = sel ? addr2   : addr1;
    assign obs_tdata  = sel ? tdata2  : tdata1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {6'b0, obs_busy, obs_done, obs_count, obs_en, obs_addr,
                obs_tvalid, obs_tlast, obs_tdata};
    endfunction

    // Per-transfer observation log
    int            cyc, n_beats, issued, done_cnt, done_cyc, first_tv, first_en, abort_cyc;
    logic [DW-1:0] bdata[$];
    logic          blast[$];
    logic [AW-1:0] alog[$];
    bit            stall_err, credit_err, tv_seen, prev_stall, finished;
    logic [DW-1:0] prev_data;
    logic [2:0]    abort_snap;

    // Called at a negedge: observe, drive tready for the coming edge, advance.
    task automatic step(input logic rdy);
        tready = rdy;
        if (obs_en) begin
            if (issued - n_beats >= 4) credit_err = 1'b1;
            alog.push_back(obs_addr);
            if (first_en < 0) first_en = cyc;
            issued++;
        end
        if (prev_stall && (!obs_tvalid || obs_tdata !== prev_data)) stall_err = 1'b1;
        prev_stall = obs_tvalid && !rdy;
        prev_data  = obs_tdata;
        if (obs_tvalid) begin
            tv_seen = 1'b1;
            if (first_tv < 0) first_tv = cyc;
        end
        if (obs_tvalid && rdy) begin
            bdata.push_back(obs_tdata);
            blast.push_back(obs_tlast);
            n_beats++;
        end
        if (obs_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(negedge clk);
        cyc++;
    endtask

    // mode 0: tready held high; mode 1: fixed irregular tready pattern
    task automatic run_xfer(input string tag, input logic [AW-1:0] base, input int len,
                            input int mode, input int abort_beat, input int restart_cyc);
        logic [15:0] pat;
        logic        rdy;
        pat = 16'b1001_1101_0011_0101;
        cyc = 0; n_beats = 0; issued = 0; done_cnt = 0; done_cyc = -1;
        first_tv = -1; first_en = -1; abort_cyc = -1;
        bdata.delete(); blast.delete(); alog.delete();
        stall_err = 0; credit_err = 0; tv_seen = 0; prev_stall = 0; finished = 0;
        abort_snap = 3'b111;
        for (int i = 0; i < 300; i++) begin
            rdy = (mode == 0) ? 1'b1 : pat[i % 16];
            if (i == 0) begin
                cfg_start = 1'b1; cfg_base = base; cfg_len = LW'(len);
            end
            if (i == restart_cyc) begin
                cfg_start = 1'b1; cfg_base = 10'h100; cfg_len = 11'd2;
            end
            if (abort_beat > 0 && abort_cyc < 0 && obs_tvalid && rdy &&
                n_beats == abort_beat - 1) begin
                cfg_abort = 1'b1;
                abort_cyc = cyc;
            end
            step(rdy);
            cfg_start = 1'b0;
            cfg_abort = 1'b0;
            if (abort_cyc >= 0 && cyc == abort_cyc + 1)
                abort_snap = {obs_tvalid, obs_busy, obs_en};
            if (done_cnt > 0 || (abort_cyc >= 0 && cyc >= abort_cyc + 3)) begin
                finished = 1'b1;
                break;
            end
        end
        tready = 1'b0;
        chk({tag, "_finish"}, 64'(finished), 64'd1);
    endtask

    task automatic check_data(input string tag, input logic [AW-1:0] base, input int n, input int len);
        for (int k = 0; k < n && k < bdata.size(); k++) begin
            chk($sformatf("%s_d%0d", tag, k), 64'(bdata[k]), 64'(((32'(base) + 32'(k)) & 32'h3FF) + 32'd1));
            chk($sformatf("%s_last%0d", tag, k), 64'(blast[k]), 64'(k == len - 1));
        end
    endtask

    task automatic check_stream(input string tag, input logic [AW-1:0] base, input int len);
        chk({tag, "_beats"}, 64'(n_beats), 64'(len));
        check_data(tag, base, len, len);
        chk({tag, "_stall_hold"}, 64'(stall_err), 64'd0);
        chk({tag, "_credit"}, 64'(credit_err), 64'd0);
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({tag, "_count"}, 64'(obs_count), 64'(len));
        chk({tag, "_busy_after"}, 64'(obs_busy), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i + 1);

        // Reset: outputs zero while asserted and on the cycle after release
        rst = 1'b1;
        repeat (3) @(negedge clk);
        sel = 1'b0; #1 chk("reset_hold_lat1", outs(), 64'd0);
        sel = 1'b1; #1 chk("reset_hold_lat2", outs(), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        sel = 1'b0; #1 chk("reset_rel_lat1", outs(), 64'd0);
        sel = 1'b1; #1 chk("reset_rel_lat2", outs(), 64'd0);
        sel = 1'b0;
        @(negedge clk);

        // Basic 4-word run, first read cycle 1, first beat cycle 3, done after last beat
        run_xfer("basic", 10'h000, 4, 0, 0, -1);
        check_stream("basic", 10'h000, 4);
        chk("basic_first_en", 64'(first_en), 64'd1);
        chk("basic_first_tv", 64'(first_tv), 64'd3);
        chk("basic_done_cyc", 64'(done_cyc), 64'd7);
        chk("basic_d3_const", 64'(bdata.size() > 3 ? bdata[3] : 32'hDEAD), 64'h4);

        // Start while busy is ignored
        run_xfer("busy_start", 10'h000, 4, 0, 0, 2);
        check_stream("busy_start", 10'h000, 4);
        chk("busy_start_nreads", 64'(alog.size()), 64'd4);
        chk("busy_start_a3", 64'(alog.size() > 3 ? alog[3] : 10'h3FF), 64'h003);

        // Backpressure, latency 1 then latency 2
        run_xfer("bp_lat1", 10'h010, 8, 1, 0, -1);
        check_stream("bp_lat1", 10'h010, 8);
        sel = 1'b1;
        run_xfer("bp_lat2", 10'h010, 8, 1, 0, -1);
        check_stream("bp_lat2", 10'h010, 8);
        sel = 1'b0;

        // Address wrap
        run_xfer("wrap", 10'h3FE, 4, 0, 0, -1);
        check_stream("wrap", 10'h3FE, 4);
        chk("wrap_addrs", {16'b0, alog.size() == 4 ? {alog[0], alog[1], alog[2], alog[3]} : 40'h0},
            {16'b0, 10'h3FE, 10'h3FF, 10'h000, 10'h001});

        // Zero length
        run_xfer("zero", 10'h005, 0, 0, 0, -1);
        chk("zero_done_cnt", 64'(done_cnt), 64'd1);
        chk("zero_done_cyc", 64'(done_cyc), 64'd2);
        chk("zero_tvalid_seen", 64'(tv_seen), 64'd0);
        chk("zero_reads", 64'(issued), 64'd0);
        chk("zero_count", 64'(obs_count), 64'd0);

        // Abort coincident with the 5th beat, then a clean restart
        run_xfer("abort", 10'h000, 16, 0, 5, -1);
        chk("abort_snap_tv_busy_en", 64'(abort_snap), 64'd0);
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_count", 64'(obs_count), 64'd5);
        chk("abort_beats", 64'(n_beats), 64'd5);
        check_data("abort", 10'h000, 5, 16);
        run_xfer("post_abort", 10'h000, 2, 0, 0, -1);
        check_stream("post_abort", 10'h000, 2);

        // Reset in the middle of a stalled transfer
        cfg_base = 10'h000; cfg_len = 11'd8; cfg_start = 1'b1;
        step(1'b0);
        cfg_start = 1'b0;
        repeat (5) step(1'b0);
        chk("midrst_tvalid_before", 64'(obs_tvalid), 64'd1);
        rst = 1'b1;
        step(1'b1);
        chk("midrst_outs", outs(), 64'd0);
        rst = 1'b0;
        step(1'b1);
        chk("midrst_after", outs(), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/bram_pixel_streamer.md
Name: bram_pixel_streamer

Overview:
- Downstream stage of the AXI4-Lite BRAM control register block; consumes its start/base/length/abort control registers.
- Reads a contiguous run of words from the BRAM read port and emits them as an AXI4-Stream master (tdata/tvalid/tready/tlast) to the image-processing pipeline.
- Reports busy, done and beat count back to the register block for software readback.

Parameters:
- ADDR_WIDTH, 10, BRAM word-address width; word addressing, not byte addressing.
- DATA_WIDTH, 32, BRAM word and stream data width.
- RD_LATENCY, 1, BRAM read latency in cycles; legal values are 1 or 2.
- FIFO_DEPTH, 4, output buffer depth; must be at least RD_LATENCY+2 and a power of 2.

Ports:
- ACLK  in  1  sole clock; all logic is on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- cfg_start  in  1  one-cycle start pulse.
- cfg_base_addr  in  ADDR_WIDTH  first word address; sampled when start is accepted.
- cfg_length  in  ADDR_WIDTH+1  number of words to send, 0..2^ADDR_WIDTH; sampled when start is accepted.
- cfg_abort  in  1  one-cycle abort pulse.
- stat_busy  out  1  high from start acceptance until done or abort.
- stat_done  out  1  one-cycle pulse on normal completion.
- stat_count  out  ADDR_WIDTH+1  number of beats handshaken in the current or last transfer.
- bram_en  out  1  BRAM read enable.
- bram_addr  out  ADDR_WIDTH  BRAM read address.
- bram_dout  in  DATA_WIDTH  BRAM read data, valid RD_LATENCY cycles after bram_en.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  high on the final beat.

Behaviour:
- Reset values: while ARESET is high, and on the cycle after it falls, all outputs are 0; FIFO is empty; FSM is IDLE.
- FSM states are IDLE, RUN and DRAIN.
- IDLE: a cfg_start pulse latches base and length, clears stat_count, sets stat_busy and moves to RUN.
  - If the latched length is 0, the FSM goes to DRAIN instead. stat_done then pulses the next cycle with no stream beats.
- RUN: issue one read per cycle (bram_en=1, bram_addr=current address) while the credit condition holds.
  - Credit condition: reads in flight + FIFO occupancy < FIFO_DEPTH. This guarantees a returning word is never dropped.
  - After each read, the address increments modulo 2^ADDR_WIDTH, so 0x3FF wraps to 0x000.
  - After the last read is issued, go to DRAIN.
- DRAIN: wait until all in-flight reads and all FIFO words have been handshaken, then go to IDLE.
  - On the transition to IDLE, stat_done pulses for one cycle and stat_busy falls in the same cycle.
- Read-return tracking:
  - An RD_LATENCY-deep valid shift register follows each issued read.
  - Data is written into the FIFO on the cycle the delayed valid bit is set.
- Stream output:
  - The FIFO head drives m_axis_tdata and m_axis_tvalid.
  - A beat transfers when tvalid and tready are both high. stat_count then increments.
  - tdata and tvalid hold stable while tvalid is high and tready is low.
  - tlast is high only on the beat where stat_count equals length-1.
  - The FIFO is first-word-fall-through: a simultaneous write and read when full is legal. A write into an empty FIFO appears at the head the next cycle.
- Latency at RD_LATENCY=1, tready held high: start accepted at cycle 0, bram_en first high at cycle 1, first tvalid at cycle 3, then one beat per cycle.
- cfg_start while busy is ignored; latched values are unchanged.
- cfg_abort while busy, effective next cycle:
  - FIFO is flushed and the valid shift register is cleared, so in-flight data is discarded.
  - bram_en=0, tvalid=0, stat_busy=0, FSM goes to IDLE.
  - stat_done does not pulse; stat_count keeps the partial value.
  - cfg_abort in IDLE has no effect. If start and abort arrive in the same cycle in IDLE, start wins.
- Mid-operation ARESET returns everything to reset values on the next edge, regardless of the stream handshake.

Decomposition:
- Package bram_stream_pkg holds:
  - the state enum (IDLE, RUN, DRAIN);
  - a localparam function for the FIFO pointer width, clog2(FIFO_DEPTH)+1;
  - the RD_LATENCY legality check, used by an elaboration-time assertion.
- Sub-module stream_fifo: a parameterised synchronous first-word-fall-through FIFO with a flush input and an occupancy output.
- The top level holds the FSM, address and credit counters, valid shift register and status logic.

Test Plan:
- Basic run: BRAM words 0..3 preloaded with 0x1..0x4; start with base=0, length=4, tready=1 → beats 0x1,0x2,0x3,0x4; tlast on 0x4; first tvalid at cycle 3 after start; stat_done one cycle after the last beat; stat_count=4.
- Backpressure: length=8, tready toggled 1-0-0-1 pseudo-randomly → all 8 beats in order; tdata stable while stalled; bram_en never issued beyond FIFO_DEPTH credits; no data lost. Repeat with RD_LATENCY=2.
- Wrap: base=0x3FE, length=4 → addresses 0x3FE, 0x3FF, 0x000, 0x001 on bram_addr; data matches the BRAM contents at those addresses.
- Zero length: start with length=0 → stat_done pulse one cycle later, no tvalid, stat_count=0.
- Abort: length=16, tready=1, abort after the 5th beat → tvalid=0 next cycle; stat_busy=0; no done pulse; stat_count=5. A following start with base=0, length=2 streams 0x1,0x2 with no stale data.
- Start while busy: a second start with a different base during RUN is ignored; the original 4-beat sequence completes unchanged.
